// File: rtl/vector_video_timing_pkg.sv
// Purpose: default raster timing for the Vector-06C video path (PAL-style
//   768x312 ce12 ticks per frame), counter widths and the interrupt length.
// Ports: none (package).
package vector_video_pkg;
  localparam int HCNT_W        = 10;
  localparam int VCNT_W        = 9;
  localparam int INT_W         = 7;

  localparam int H_TOTAL       = 768;
  localparam int H_ACT_START   = 96;
  localparam int H_ACTIVE      = 512;
  localparam int H_BLANK_START = 640;
  localparam int HSYNC_START   = 672;
  localparam int HSYNC_LEN     = 56;

  localparam int V_TOTAL       = 312;
  localparam int V_ACT_START   = 40;
  localparam int V_ACTIVE      = 256;
  localparam int V_BLANK_START = 298;
  localparam int VSYNC_START   = 300;
  localparam int VSYNC_LEN     = 4;

  localparam int INT_LEN       = 96;
endpackage

// File: rtl/vector_video_timing_counter.sv
// Purpose: modulo-N up-counter advancing on an enable, with a combinational
//   wrap pulse (en high while the count sits at N-1).
// Ports:
//   clk   in  1  clock
//   rst_n in  1  asynchronous active-low reset (count returns to 0)
//   en    in  1  advance enable
//   cnt   out W  current count 0..N-1
//   wrap  out 1  en && cnt==N-1; the count returns to 0 on this edge
module vvt_ce_counter #(
  parameter int W = 10,
  parameter int N = 768
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  localparam logic [W-1:0] LAST = W'(N - 1);

  assign wrap = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/vector_video_timing.sv
// Purpose: raster timing generator for the Vector-06C video path. Counts the
//   12 MHz pixel enable in the clk24 domain into line/frame positions and
//   publishes syncs, blanking, active/border flags, framebuffer fetch
//   strobes/addresses (with vertical scroll) and the frame interrupt request.
// Ports:
//   clk24        in  1  24 MHz clock
//   reset_n      in  1  asynchronous active-low reset
//   ce12         in  1  pixel enable, one clk24 in two
//   scroll_data  in  8  vertical scroll value
//   scroll_we    in  1  capture scroll_data into the pending scroll register
//   hsync_n      out 1  horizontal sync, active low
//   vsync_n      out 1  vertical sync, active low
//   blank        out 1  horizontal or vertical blank
//   active       out 1  inside the active picture window
//   border       out 1  neither blank nor active
//   fetch_strobe out 1  one-clk24 fetch request for fetch_col/fetch_row
//   fetch_col    out 5  byte column of the fetch
//   fetch_row    out 8  framebuffer row of the fetch
//   frame_start  out 1  one-clk24 pulse at position (0,0)
//   int_rq       out 1  CPU frame interrupt request
module vector_video_timing
  import vector_video_pkg::*;
#(
  parameter int H_TOTAL       = vector_video_pkg::H_TOTAL,
  parameter int H_ACT_START   = vector_video_pkg::H_ACT_START,
  parameter int H_ACTIVE      = vector_video_pkg::H_ACTIVE,
  parameter int H_BLANK_START = vector_video_pkg::H_BLANK_START,
  parameter int HSYNC_START   = vector_video_pkg::HSYNC_START,
  parameter int HSYNC_LEN     = vector_video_pkg::HSYNC_LEN,
  parameter int V_TOTAL       = vector_video_pkg::V_TOTAL,
  parameter int V_ACT_START   = vector_video_pkg::V_ACT_START,
  parameter int V_ACTIVE      = vector_video_pkg::V_ACTIVE,
  parameter int V_BLANK_START = vector_video_pkg::V_BLANK_START,
  parameter int VSYNC_START   = vector_video_pkg::VSYNC_START,
  parameter int VSYNC_LEN     = vector_video_pkg::VSYNC_LEN,
  parameter int INT_LEN       = vector_video_pkg::INT_LEN
) (
  input  logic       clk24,
  input  logic       reset_n,
  input  logic       ce12,
  input  logic [7:0] scroll_data,
  input  logic       scroll_we,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank,
  output logic       active,
  output logic       border,
  output logic       fetch_strobe,
  output logic [4:0] fetch_col,
  output logic [7:0] fetch_row,
  output logic       frame_start,
  output logic       int_rq
);

  if (H_ACT_START < 16 || HSYNC_START < H_BLANK_START ||
      HSYNC_START + HSYNC_LEN > H_TOTAL ||
      H_ACT_START + H_ACTIVE > H_BLANK_START) begin : g_param_check
    $error("vector_video_timing: inconsistent horizontal timing parameters");
  end

  logic              started;
  logic              at_top;
  logic              vld_p0;
  logic              h_en;
  logic              h_wrap;
  logic              v_wrap;
  logic              int_en;
  logic              int_wrap;
  logic [HCNT_W-1:0] hcnt;
  logic [VCNT_W-1:0] vcnt;
  logic [INT_W-1:0]  int_cnt;
  logic [7:0]        scroll_pend;
  logic [7:0]        scroll_cur;

  // The first ce12 after reset publishes position (0,0) instead of advancing,
  // so the first frame after release begins at the top-left corner.
  assign h_en   = ce12 && started;
  assign int_en = vld_p0 && int_rq;

  vvt_ce_counter #(.W(HCNT_W), .N(H_TOTAL)) u_hcnt (
    .clk(clk24), .rst_n(reset_n), .en(h_en), .cnt(hcnt), .wrap(h_wrap)
  );

  vvt_ce_counter #(.W(VCNT_W), .N(V_TOTAL)) u_vcnt (
    .clk(clk24), .rst_n(reset_n), .en(h_wrap), .cnt(vcnt), .wrap(v_wrap)
  );

  vvt_ce_counter #(.W(INT_W), .N(INT_LEN)) u_int_cnt (
    .clk(clk24), .rst_n(reset_n), .en(int_en), .cnt(int_cnt), .wrap(int_wrap)
  );

  // at_top tracks "counters are at (0,0)" so frame_start needs no full compare.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      started <= 1'b0;
      at_top  <= 1'b1;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= ce12;
      if (ce12) started <= 1'b1;
      if (h_en) at_top <= v_wrap;
    end
  end

  // ---- stage p0: decode of the freshly advanced counters ----
  logic       hs_p0, vs_p0, hact_p0, vact_p0, blank_p0, fetch_win_p0;
  logic       fetch_hit_p0, int_start_p0;
  logic [8:0] fetch_off_p0;
  logic [7:0] row_p0;

  assign hs_p0   = (int'(hcnt) >= HSYNC_START) && (int'(hcnt) < HSYNC_START + HSYNC_LEN);
  assign vs_p0   = (int'(vcnt) >= VSYNC_START) && (int'(vcnt) < VSYNC_START + VSYNC_LEN);
  assign hact_p0 = (int'(hcnt) >= H_ACT_START) && (int'(hcnt) < H_ACT_START + H_ACTIVE);
  assign vact_p0 = (int'(vcnt) >= V_ACT_START) && (int'(vcnt) < V_ACT_START + V_ACTIVE);
  assign blank_p0 = (int'(hcnt) >= H_BLANK_START) || (int'(vcnt) >= V_BLANK_START);

  // Fetch runs 16 ticks ahead of the pixels it feeds.
  assign fetch_off_p0 = 9'(hcnt - HCNT_W'(H_ACT_START - 16));
  assign fetch_win_p0 = (int'(hcnt) >= H_ACT_START - 16) &&
                        (int'(hcnt) <  H_ACT_START - 16 + H_ACTIVE);
  assign fetch_hit_p0 = vact_p0 && fetch_win_p0 && (fetch_off_p0[3:0] == 4'd0);
  // Framebuffer rows count downward from the scroll value, modulo 256.
  assign row_p0 = scroll_cur - 8'(vcnt - VCNT_W'(V_ACT_START));

  // Idle int counter guards against retriggering inside a running pulse.
  assign int_start_p0 = (hcnt == '0) && (int'(vcnt) == VSYNC_START) && (int_cnt == '0);

  // ---- stage p1: registered outputs, updated one clk24 after each ce12 ----
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      hsync_n      <= 1'b1;
      vsync_n      <= 1'b1;
      blank        <= 1'b1;
      active       <= 1'b0;
      border       <= 1'b0;
      fetch_strobe <= 1'b0;
      fetch_col    <= 5'd0;
      fetch_row    <= 8'hFF;
      frame_start  <= 1'b0;
      int_rq       <= 1'b0;
    end else if (vld_p0) begin
      hsync_n      <= !hs_p0;
      vsync_n      <= !vs_p0;
      blank        <= blank_p0;
      active       <= hact_p0 && vact_p0;
      border       <= !blank_p0 && !(hact_p0 && vact_p0);
      fetch_strobe <= fetch_hit_p0;
      frame_start  <= at_top;
      if (fetch_hit_p0) begin
        fetch_col <= fetch_off_p0[8:4];
        fetch_row <= row_p0;
      end
      if (int_start_p0) int_rq <= 1'b1;
      else if (int_wrap) int_rq <= 1'b0;
    end else begin
      fetch_strobe <= 1'b0;
      frame_start  <= 1'b0;
    end
  end

  // A write landing with frame_start still lands in pend; cur takes the old pend.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      scroll_pend <= 8'hFF;
      scroll_cur  <= 8'hFF;
    end else begin
      if (scroll_we)   scroll_pend <= scroll_data;
      if (frame_start) scroll_cur  <= scroll_pend;
    end
  end
endmodule
